// File: rtl/ampel_phasengeber.sv
// Traffic-light phase generator: tick divider, 3-bit phase counter and pedestrian request path.
// Define KNOPF_ENTPRELLUNG_EN to debounce the synchronized button level over ENTPRELL_ZYKLEN samples.
module ampel_phasengeber #(
   parameter int TICKS_PRO_PHASE = 8,
   parameter int ENTPRELL_ZYKLEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       freigabe,
   input  logic       knopf_roh,
   input  logic       knopf_quit,
   output logic [2:0] counter,
   output logic       phase_tick,
   output logic       knopf,
   output logic       knopf_puls
);

   localparam int DIV_W = $clog2(TICKS_PRO_PHASE);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PRO_PHASE - 1);

   if (TICKS_PRO_PHASE < 2 || TICKS_PRO_PHASE > 255) begin : g_bad_ticks
      $error("TICKS_PRO_PHASE must be within 2..255");
   end
   if (ENTPRELL_ZYKLEN < 1 || ENTPRELL_ZYKLEN > 15) begin : g_bad_entprell
      $error("ENTPRELL_ZYKLEN must be within 1..15");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       counter_q, counter_d;
   logic             tick_q, tick_d;
   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             puls_q, puls_d;
   logic             req_q, req_d;

   always_comb begin
      div_d     = div_q;
      counter_d = counter_q;
      tick_d    = 1'b0;
      if (freigabe) begin
         if (div_q == DIV_LAST) begin
            div_d     = '0;
            counter_d = counter_q + 3'd1;
            tick_d    = 1'b1;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

`ifdef KNOPF_ENTPRELLUNG_EN
   logic [3:0] stab_q, stab_d;

   // A candidate level must be seen ENTPRELL_ZYKLEN times in a row; any sample equal to the accepted level restarts.
   always_comb begin
      level_d = level_q;
      stab_d  = '0;
      if (sync2_q != level_q) begin
         if (stab_q == 4'(ENTPRELL_ZYKLEN - 1)) begin
            level_d = sync2_q;
         end else begin
            stab_d = stab_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stab_q <= '0;
      end else begin
         stab_q <= stab_d;
      end
   end
`else
   assign level_d = sync2_q;
`endif

   assign puls_d = level_d & ~level_q;
   // A fresh press wins over a simultaneous acknowledge so it is never lost.
   assign req_d  = puls_q | (req_q & ~knopf_quit);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         counter_q <= '0;
         tick_q    <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         puls_q    <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         counter_q <= counter_d;
         tick_q    <= tick_d;
         sync1_q   <= knopf_roh;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         puls_q    <= puls_d;
         req_q     <= req_d;
      end
   end

   assign counter    = counter_q;
   assign phase_tick = tick_q;
   assign knopf      = req_q;
   assign knopf_puls = puls_q;

endmodule

// File: tb/tb_ampel_phasengeber.sv
// Bench for ampel_phasengeber: arithmetic reference model checked every cycle plus directed literal checks.
// Honours KNOPF_ENTPRELLUNG_EN the same way as the design.
module tb_ampel_phasengeber;

   localparam int T = 4;
   localparam int N = 4;
`ifdef KNOPF_ENTPRELLUNG_EN
   localparam int EXP_AT_PRESS = 7;
   localparam int EXP_AT_RST   = 6;
`else
   localparam int EXP_AT_PRESS = 2;
   localparam int EXP_AT_RST   = 3;
`endif

   logic       clk = 1'b0;
   logic       rst, freigabe, knopf_roh, knopf_quit;
   logic [2:0] counter;
   logic       phase_tick, knopf, knopf_puls;

   int n_chk = 0;
   int n_err = 0;

   ampel_phasengeber #(.TICKS_PRO_PHASE(T), .ENTPRELL_ZYKLEN(N)) dut (
      .clk(clk), .rst(rst), .freigabe(freigabe), .knopf_roh(knopf_roh),
      .knopf_quit(knopf_quit), .counter(counter), .phase_tick(phase_tick),
      .knopf(knopf), .knopf_puls(knopf_puls)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: enabled-tick count gives divider/counter; button via sample history and run length.
   int   en_cnt = 0;
   bit   m_valid = 0, m_tick = 0, m_puls = 0, m_latch = 0, m_acc = 0;
   bit   r1 = 0, r2 = 0, s = 0, last_s = 0, new_acc = 0;
   int   run = 0;

   always @(posedge clk) begin
      if (rst) begin
         en_cnt = 0; m_tick = 0; m_puls = 0; m_latch = 0; m_acc = 0;
         r1 = 0; r2 = 0; last_s = 0; run = 0;
      end else begin
         m_latch = m_puls | (m_latch & ~knopf_quit);
         m_tick  = freigabe && (en_cnt % T == T - 1);
         if (freigabe) en_cnt++;
         s  = r2;
         r2 = r1;
         r1 = knopf_roh;
`ifdef KNOPF_ENTPRELLUNG_EN
         if (run > 0 && s == last_s) run++;
         else run = 1;
         last_s  = s;
         new_acc = m_acc;
         if (s != m_acc && run >= N) new_acc = s;
`else
         new_acc = s;
`endif
         m_puls = new_acc & ~m_acc;
         m_acc  = new_acc;
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cmp_counter", 32'(counter), 32'((en_cnt / T) % 8));
         check("cmp_phase_tick", 32'(phase_tick), 32'(m_tick));
         check("cmp_knopf", 32'(knopf), 32'(m_latch));
         check("cmp_knopf_puls", 32'(knopf_puls), 32'(m_puls));
      end
   end

   logic pat [20];
   int   ticks, adj, pc, at;
   logic prev_tick;

   initial begin
      for (int i = 0; i < 20; i++) pat[i] = 1'b0;
`ifdef KNOPF_ENTPRELLUNG_EN
      pat[0] = 1'b1;
      for (int i = 2; i <= 10; i++) pat[i] = 1'b1;
`else
      pat[0] = 1'b1;
`endif
      rst = 1'b1; freigabe = 1'b0; knopf_roh = 1'b0; knopf_quit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_counter", 32'(counter), 32'd0);
      check("rst_knopf", 32'(knopf), 32'd0);

      // Free run from reset release
      rst = 1'b0; freigabe = 1'b1;
      ticks = 0; adj = 0; prev_tick = 1'b0;
      for (int i = 1; i <= 36; i++) begin
         @(posedge clk); #1;
         if (phase_tick) begin
            ticks++;
            if (prev_tick) adj++;
         end
         prev_tick = phase_tick;
         if (i == 3) check("run_counter_c3", 32'(counter), 32'd0);
         if (i == 4) begin
            check("run_counter_c4", 32'(counter), 32'd1);
            check("run_tick_c4", 32'(phase_tick), 32'd1);
         end
         if (i == 32) check("run_counter_wrap", 32'(counter), 32'd0);
      end
      check("run_tick_count", 32'(ticks), 32'd9);
      check("run_tick_width", 32'(adj), 32'd0);

      // Freeze at divider 2
      repeat (2) begin @(posedge clk); #1; end
      freigabe = 1'b0;
      ticks = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (phase_tick) ticks++;
      end
      check("frz_counter", 32'(counter), 32'd1);
      check("frz_ticks", 32'(ticks), 32'd0);
      freigabe = 1'b1;
      @(posedge clk); #1;
      check("ret1_counter", 32'(counter), 32'd1);
      check("ret1_tick", 32'(phase_tick), 32'd0);
      @(posedge clk); #1;
      check("ret2_counter", 32'(counter), 32'd2);
      check("ret2_tick", 32'(phase_tick), 32'd1);

      // Button press
      pc = 0; at = -10;
      for (int i = 0; i < 20; i++) begin
         knopf_roh = pat[i];
         @(posedge clk); #1;
         if (knopf_puls) begin pc++; at = i; end
      end
      check("press_puls_count", 32'(pc), 32'd1);
      check("press_puls_at", 32'(at), 32'(EXP_AT_PRESS));
      check("press_knopf", 32'(knopf), 32'd1);

      // Press with acknowledge in the strobe cycle, then acknowledge again
      pc = 0; at = -10;
      for (int i = 0; i < 20; i++) begin
         knopf_roh = pat[i];
         @(posedge clk); #1;
         if (knopf_puls) begin
            pc++; at = i; knopf_quit = 1'b1;
         end else if (at == i - 1) begin
            check("quit_same_knopf", 32'(knopf), 32'd1);
            knopf_quit = 1'b1;
         end else if (at == i - 2) begin
            check("quit_next_knopf", 32'(knopf), 32'd0);
            knopf_quit = 1'b0;
         end else begin
            knopf_quit = 1'b0;
         end
      end
      knopf_quit = 1'b0;
      check("quit_puls_count", 32'(pc), 32'd1);
      check("quit_puls_at", 32'(at), 32'(EXP_AT_PRESS));

      // Button held through reset
      knopf_roh = 1'b1;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("hrst_counter", 32'(counter), 32'd0);
         check("hrst_tick", 32'(phase_tick), 32'd0);
         check("hrst_knopf", 32'(knopf), 32'd0);
         check("hrst_puls", 32'(knopf_puls), 32'd0);
      end
      rst = 1'b0;
      pc = 0; at = -10;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (knopf_puls) begin pc++; at = i; end
      end
      check("hrst_puls_count", 32'(pc), 32'd1);
      check("hrst_puls_at", 32'(at), 32'(EXP_AT_RST));
      check("hrst_knopf_set", 32'(knopf), 32'd1);

      knopf_roh = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ampel_phasengeber.md
AMPEL_PHASENGEBER -- requirements
Module: ampel_phasengeber

Interface
REQ-001 The module SHALL have parameter TICKS_PRO_PHASE, default 8: clock cycles per counter step, legal range 2..255.
REQ-002 The module SHALL have parameter ENTPRELL_ZYKLEN, default 4: consecutive stable synchronized samples required to accept a new button level, legal range 1..15.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port freigabe, input, 1 bit: run enable for the tick divider; 0 freezes divider and counter.
REQ-006 The module SHALL have port knopf_roh, input, 1 bit: raw pedestrian button, asynchronous to clk.
REQ-007 The module SHALL have port knopf_quit, input, 1 bit: downstream acknowledge that clears the pending request.
REQ-008 The module SHALL have port counter, output, 3 bits: phase index driven to the downstream traffic-light decoder.
REQ-009 The module SHALL have port phase_tick, output, 1 bit: one-cycle strobe on every counter step.
REQ-010 The module SHALL have port knopf, output, 1 bit: pending request level driven to the downstream decoder.
REQ-011 The module SHALL have port knopf_puls, output, 1 bit: one-cycle strobe per accepted button press.

Function
REQ-012 knopf_roh SHALL pass through a two-flop synchronizer before any other use, giving 2 cycles latency.
REQ-013 The divider SHALL count 0..TICKS_PRO_PHASE-1 while freigabe=1 and hold its value while freigabe=0.
REQ-014 When the divider is at TICKS_PRO_PHASE-1 and freigabe=1, the next edge SHALL reset the divider to 0, increment counter, and assert phase_tick for exactly that following cycle.
REQ-015 counter SHALL wrap 7 -> 0 with no extra or skipped step.
REQ-016 Deasserting freigabe on the terminal divider cycle SHALL suppress the step; no phase_tick is produced until freigabe returns and the terminal count is reached again.
REQ-017 knopf_puls SHALL assert for one cycle on each 0->1 transition of the accepted (debounced or synchronized) button level; holding the button SHALL NOT retrigger it.
REQ-018 The request latch SHALL set on knopf_puls and clear on knopf_quit; knopf SHALL equal the latch output.
REQ-019 When knopf_puls and knopf_quit occur in the same cycle, the latch SHALL be set, so the new press is not lost.
REQ-020 knopf_puls while the latch is already set SHALL leave it set; no counting or queueing of presses is performed.
REQ-021 knopf_quit while the latch is clear SHALL have no effect.
REQ-022 Request path and divider SHALL be independent; a press SHALL never alter counter timing.

Reset
REQ-023 While rst=1 at a clock edge: counter=0, divider=0, phase_tick=0, knopf=0, knopf_puls=0, synchronizer and debounce state=0, accepted level=0.
REQ-024 Reset asserted mid-phase or mid-debounce SHALL discard all partial state; counting resumes from divider=0 on the first edge with rst=0.
REQ-025 A button held through reset release SHALL produce exactly one knopf_puls, once acceptance completes.

Configuration
REQ-026 Macro KNOPF_ENTPRELLUNG_EN defined: a new synchronized level SHALL be accepted only after ENTPRELL_ZYKLEN consecutive equal samples; any differing sample restarts the count.
REQ-027 Macro KNOPF_ENTPRELLUNG_EN undefined: the synchronized level SHALL be accepted directly; ENTPRELL_ZYKLEN is ignored and no debounce logic exists.

Verification (bench: TICKS_PRO_PHASE=4, ENTPRELL_ZYKLEN=4)
REQ-028 Release rst with freigabe=1 and run 36 cycles -> counter steps every 4 cycles 0..7 then 0; phase_tick occurs 9 times, each 1 cycle wide.
REQ-029 Drop freigabe for 10 cycles at divider=2 -> counter frozen; the step occurs 1 cycle after freigabe returns, on reaching divider=3.
REQ-030 With the macro defined, drive knopf_roh 1-0-1 bounce in 3 cycles, then hold 1 for 8 cycles -> exactly one knopf_puls, 2+4 cycles after the stable level begins; knopf=1 until knopf_quit.
REQ-031 With the macro undefined, a 1-cycle knopf_roh pulse -> knopf_puls 3 cycles later and knopf=1.
REQ-032 Assert knopf_quit in the knopf_puls cycle -> knopf remains 1; a quit pulse one cycle later -> knopf=0.
REQ-033 Hold knopf_roh=1 across a 3-cycle rst -> all outputs 0 during reset; exactly one knopf_puls after release.
